// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexed N-digit hex seven-segment driver (Basys3 style display).
//   Each digit gets a slot of DIGIT_CYCLES clocks. The first GAP_CYCLES of a
//   slot keep every anode off so the previous digit cannot ghost. The rest of
//   the slot lights the selected digit. Supports per-digit blanking, decimal
//   points and leading-zero suppression. New display data enters through a
//   valid/ready port into a one-entry pending buffer. That buffer is copied to
//   the active registers only at the end of a frame, so the display never
//   tears mid-frame.
//
// Ports
//   clk_i        system clock
//   rst_ni       asynchronous reset, active low
//   upd_valid_i  update request
//   upd_ready_o  pending buffer free (an update is accepted when valid&&ready)
//   digits_i     nibble i -> digit i, digit 0 is the rightmost digit
//   dp_i         decimal point per digit
//   blank_i      force digit dark (segments and dp)
//   lz_en_i      leading-zero suppression enable, used live
//   seg_o        segments, seg_o[0]=A .. seg_o[6]=G
//   dp_o         decimal point
//   an_o         digit anodes, one-hot when lit
//   frame_o      high on the last cycle of each frame
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_CYCLES = 1000,
  parameter int GAP_CYCLES   = 50,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    upd_valid_i,
  output logic                    upd_ready_o,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    lz_en_i,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Output levels that mean "off" for the chosen polarity.
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0]            SEG_OFF = ACTIVE_LOW ? '1 : '0;
  localparam logic                  DP_OFF  = ACTIVE_LOW;

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] dig;
    logic [NUM_DIGITS-1:0]      dp;
    logic [NUM_DIGITS-1:0]      blank;
  } disp_t;

  typedef enum logic {
    S_GAP = 1'b0,
    S_ON  = 1'b1
  } phase_t;

  localparam phase_t PHASE_RST = (GAP_CYCLES > 0) ? S_GAP : S_ON;

  // Hex to active-high segments {G,F,E,D,C,B,A}.
  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'h3F;
      4'h1: hex_decode = 7'h06;
      4'h2: hex_decode = 7'h5B;
      4'h3: hex_decode = 7'h4F;
      4'h4: hex_decode = 7'h66;
      4'h5: hex_decode = 7'h6D;
      4'h6: hex_decode = 7'h7D;
      4'h7: hex_decode = 7'h07;
      4'h8: hex_decode = 7'h7F;
      4'h9: hex_decode = 7'h6F;
      4'hA: hex_decode = 7'h77;
      4'hB: hex_decode = 7'h7C;
      4'hC: hex_decode = 7'h39;
      4'hD: hex_decode = 7'h5E;
      4'hE: hex_decode = 7'h79;
      default: hex_decode = 7'h71;
    endcase
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slot_end, frame_end;
  phase_t           state_q, state_d;

  disp_t active_q, pending_q;
  logic  pending_vld_q;
  logic  accept;

  logic [NUM_DIGITS-1:0] lz_sup;
  logic [NUM_DIGITS-1:0] an_raw;
  logic [6:0]            seg_raw;
  logic                  dp_raw;

  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;
  logic                  dp_q;

  // ---------------------------------------------------------------------------
  // Slot counter and digit index
  // ---------------------------------------------------------------------------
  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (slot_end) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      state_q <= PHASE_RST;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero mask: digit i (i>0) is suppressed when it and every higher
  // digit are zero. Walk from the top digit down, keeping an "all zero so far".
  // ---------------------------------------------------------------------------
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_sup   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero  = all_zero && (active_q.dig[i] == 4'h0);
      lz_sup[i] = all_zero && (i > 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Slot FSM: next phase plus the active-high display values for this cycle.
  // The phase register always describes the current cnt_q, so the next phase
  // is decided from where the counter is about to go.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    an_raw  = '0;
    seg_raw = '0;
    dp_raw  = 1'b0;

    if (GAP_CYCLES == 0)                       state_d = S_ON;
    else if (slot_end)                         state_d = S_GAP;
    else if (int'(cnt_q) == GAP_CYCLES - 1)    state_d = S_ON;

    if (state_q == S_ON) begin
      an_raw[idx_q] = 1'b1;
      if (!active_q.blank[idx_q]) begin
        dp_raw = active_q.dp[idx_q];
        if (!(lz_en_i && lz_sup[idx_q])) seg_raw = hex_decode(active_q.dig[idx_q]);
      end
    end
  end

  // Output register: polarity applied here so the pins never glitch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      an_q  <= AN_OFF;
      seg_q <= SEG_OFF;
      dp_q  <= DP_OFF;
    end else begin
      an_q  <= ACTIVE_LOW ? ~an_raw  : an_raw;
      seg_q <= ACTIVE_LOW ? ~seg_raw : seg_raw;
      dp_q  <= ACTIVE_LOW ? ~dp_raw  : dp_raw;
    end
  end

  // ---------------------------------------------------------------------------
  // Update handshake. The pending entry is only drained at frame end. An
  // accept on the frame-end cycle itself lands in pending (it was empty, so
  // there is nothing to apply) and waits a full frame.
  // ---------------------------------------------------------------------------
  assign accept = upd_valid_i && !pending_vld_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q.dig    <= '0;
      active_q.dp     <= '0;
      active_q.blank  <= '1;
      pending_q.dig   <= '0;
      pending_q.dp    <= '0;
      pending_q.blank <= '1;
      pending_vld_q   <= 1'b0;
    end else begin
      if (frame_end && pending_vld_q) begin
        active_q      <= pending_q;
        pending_vld_q <= 1'b0;
      end
      if (accept) begin
        pending_q.dig   <= digits_i;
        pending_q.dp    <= dp_i;
        pending_q.blank <= blank_i;
        pending_vld_q   <= 1'b1;
      end
    end
  end

  assign upd_ready_o = !pending_vld_q;
  assign frame_o     = frame_end;
  assign an_o        = an_q;
  assign seg_o       = seg_q;
  assign dp_o        = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Self-checking bench for seg7_scan_driver with 4 digits, 8-cycle slots,
//   a 2-cycle gap and active-low pins. The reference tracks the display as a
//   position inside a 32-cycle frame, plus the active and pending data words.
//   Expected pin values are derived from that position with plain arithmetic.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int N   = 4;
  localparam int DC  = 8;
  localparam int GAP = 2;
  localparam int FRM = N * DC;

  logic        gclk = 1'b0;
  logic        rst_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        lz_en;
  logic [6:0]  seg;
  logic        dp_pin;
  logic [3:0]  an;
  logic        frame;

  seg7_scan_driver #(
    .NUM_DIGITS(N), .DIGIT_CYCLES(DC), .GAP_CYCLES(GAP), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk_i(gclk), .rst_ni(rst_n),
    .upd_valid_i(upd_valid), .upd_ready_o(upd_ready),
    .digits_i(digits), .dp_i(dp), .blank_i(blank), .lz_en_i(lz_en),
    .seg_o(seg), .dp_o(dp_pin), .an_o(an), .frame_o(frame)
  );

  always #5 gclk = ~gclk;

  // Active-high segment table {G..A}, indexed by nibble.
  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int n_chk = 0;
  int n_fail = 0;

  // Reference state
  int          m_pos;
  logic [15:0] m_act_dig, m_pnd_dig;
  logic [3:0]  m_act_dp, m_pnd_dp, m_act_bl, m_pnd_bl;
  bit          m_pnd_v;
  bit          m_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pos     = 0;
    m_act_dig = '0; m_act_dp = '0; m_act_bl = '1;
    m_pnd_dig = '0; m_pnd_dp = '0; m_pnd_bl = '1;
    m_pnd_v   = 0;
  endtask

  // One clock: predict the registered outputs from the pre-edge state, advance
  // the reference, then compare just after the edge.
  task automatic tick();
    int d, c;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_fr, e_rdy, dark;
    logic [15:0] upper;
    d = m_pos / DC;
    c = m_pos % DC;
    e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    if (c >= GAP) begin
      e_an  = ~(4'b0001 << d);
      upper = m_act_dig >> (4 * d);
      dark  = m_act_bl[d] || (lz_en && d > 0 && upper == 16'h0);
      if (!dark) e_seg = ~seg_tab[upper[3:0]];
      e_dp  = !(m_act_dp[d] && !m_act_bl[d]);
    end
    m_acc = upd_valid && !m_pnd_v;
    if (m_pos == FRM - 1 && m_pnd_v) begin
      m_act_dig = m_pnd_dig; m_act_dp = m_pnd_dp; m_act_bl = m_pnd_bl;
      m_pnd_v = 0;
    end
    if (m_acc) begin
      m_pnd_dig = digits; m_pnd_dp = dp; m_pnd_bl = blank;
      m_pnd_v = 1;
    end
    m_pos = (m_pos + 1) % FRM;
    e_fr  = (m_pos == FRM - 1);
    e_rdy = !m_pnd_v;
    @(posedge gclk);
    #1;
    check("an",    32'(an),        32'(e_an));
    check("seg",   32'(seg),       32'(e_seg));
    check("dp",    32'(dp_pin),    32'(e_dp));
    check("frame", 32'(frame),     32'(e_fr));
    check("ready", 32'(upd_ready), 32'(e_rdy));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
    digits = d; dp = p; blank = b; upd_valid = 1'b1;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic wait_pos(input int p);
    while (m_pos != p) tick();
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; upd_valid = 1'b0; digits = '0; dp = '0; blank = '0; lz_en = 1'b0;
    model_reset();
    #12;
    check("rst_an",    32'(an),        32'hF);
    check("rst_seg",   32'(seg),       32'h7F);
    check("rst_dp",    32'(dp_pin),    32'h1);
    check("rst_frame", 32'(frame),     32'h0);
    check("rst_ready", 32'(upd_ready), 32'h1);
    @(posedge gclk); #1;
    rst_n = 1'b1;

    // Idle after reset: dark display, frame pulse every 32 cycles.
    run(70);

    // Basic digits 3210.
    send(16'h3210, 4'h0, 4'h0);
    run(70);

    // Every nibble on digit 0.
    for (int v = 0; v < 16; v++) begin
      send({12'h000, 4'(v)}, 4'h0, 4'h0);
      run(64);
    end

    // Leading-zero suppression on and off.
    lz_en = 1'b1;
    send(16'h0050, 4'b0101, 4'h0);
    run(64);
    lz_en = 1'b0;
    run(32);

    // A mid-frame, then B held until accepted after A is applied.
    wait_pos(10);
    send(16'hA1A2, 4'b0011, 4'h0);
    digits = 16'hBEEF; dp = 4'b1000; blank = 4'b0010; upd_valid = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!m_acc && guard < 100);
    upd_valid = 1'b0;
    check("b_accepted", 32'(m_acc), 32'h1);
    run(70);

    // Accept on the frame_o cycle: applied one frame later.
    wait_pos(FRM - 1);
    send(16'hC0DE, 4'b0100, 4'h0);
    run(70);

    // Reset during an ON slot with an update pending.
    wait_pos(0);
    send(16'h7777, 4'hF, 4'h0);
    wait_pos(12);
    check("pend_before_rst", 32'(upd_ready), 32'h0);
    rst_n = 1'b0;
    #1;
    check("arst_an",    32'(an),        32'hF);
    check("arst_seg",   32'(seg),       32'h7F);
    check("arst_dp",    32'(dp_pin),    32'h1);
    check("arst_ready", 32'(upd_ready), 32'h1);
    @(posedge gclk); #1;
    check("hold_an", 32'(an), 32'hF);
    rst_n = 1'b1;
    model_reset();
    run(70);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      upd_valid = ($urandom_range(0, 7) == 0);
      digits    = 16'($urandom);
      if ($urandom_range(0, 2) == 0) digits = digits & 16'h00FF;
      dp        = 4'($urandom);
      blank     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
      tick();
    end
    upd_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
